bp_be_stride_prefetch_gen: RTL
==============================

Name: bp_be_stride_prefetch_gen

Overview:
- Sits directly downstream of the back-end stride detector.
- Consumes its registered start/confirm discovery pulses plus PC, effective address and stride, and keeps a small table of confirmed load streams.
- Emits a ready/valid stream of prefetch addresses toward the dcache prefetch port: prefetch_degree_p addresses per confirmation, prefetch_distance_p strides ahead.
- Prefetches are hints: dropping one is legal, issuing a wrong address is not.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p.
- stride_width_p, 8, width of the incoming stride; two's-complement signed bytes.
- effective_addr_width_p, vaddr_width_p, width of effective and prefetch addresses.
- streams_p, 4, number of tracked streams; must be a power of 2 and at least 2.
- prefetch_degree_p, 2, prefetches issued per confirmation; range 1..7.
- prefetch_distance_p, 1, strides ahead of the current address for the first prefetch; range 1..3.
- line_offset_width_p, 6, log2 of the cache block size in bytes; used for line dedupe.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- start_discovery_i  in  1  detector saw a new or changed stride for striding_pc_i.
- confirm_discovery_i  in  1  detector confirmed the stride for striding_pc_i.
- striding_pc_i  in  vaddr_width_p  PC of the load/store.
- eff_addr_i  in  effective_addr_width_p  effective address of that access.
- stride_i  in  stride_width_p  signed stride.
- flush_i  in  1  invalidate all streams; for context switch or fence.
- pf_v_o  out  1  prefetch request valid.
- pf_addr_o  out  effective_addr_width_p  prefetch byte address.
- pf_ready_i  in  1  consumer accepts the request.
- stream_v_o  out  streams_p  per-entry valid bits, for debug and perf counters.

Behaviour:
- Reset (reset_n_i low at a clk_i edge):
  - All entries invalid; victim pointer and arbiter pointer cleared.
  - pf_v_o=0, pf_addr_o=0, stream_v_o=0.
  - Reset asserted mid-stream discards pending and presented prefetches with no handshake.
- Entry fields: v, pc, next_addr, stride (sign-extended to effective_addr_width_p), rem (remaining count, 0..prefetch_degree_p), last_line (line address of the last issued prefetch, plus a valid bit).
- Confirm with stride_i != 0:
  - Fully associative PC lookup.
  - Hit: update stride; next_addr = eff_addr_i + stride*prefetch_distance_p (modulo 2^effective_addr_width_p); rem = prefetch_degree_p; last_line kept.
  - Miss: allocate the lowest-index invalid entry; if none, the victim pointer entry, then the pointer increments and wraps at streams_p. last_line is marked invalid.
- Confirm with stride_i == 0: ignored.
- start_discovery_i: on a PC hit, the entry is invalidated; on a miss, no effect.
- start and confirm in the same cycle: confirm wins.
- Inputs are captured at the edge ending the cycle they are valid; there is no input handshake, and the block accepts one event per cycle.
- Issue:
  - A round-robin arbiter picks among valid entries with rem > 0, starting after the last granted index.
  - The output register loads when pf_v_o=0, or when pf_v_o and pf_ready_i are both 1.
  - On load: pf_addr_o = next_addr; the entry's next_addr += stride, rem -= 1, and last_line = pf_addr_o line.
  - Dedupe: if the selected next_addr line equals last_line, the entry advances (next_addr += stride, rem -= 1) without loading the output register. That cycle produces no request.
- Latency: confirm sampled at edge E, so the entry is written at E. The arbiter selects in the following cycle, and pf_v_o is first high in the cycle after edge E+1 (2 cycles from the confirm input to the request).
- Handshake:
  - While pf_v_o=1 and pf_ready_i=0, pf_addr_o is held stable.
  - The only exception is flush_i, which may drop pf_v_o.
- Write/issue conflict: an entry written by confirm or start in the same cycle is excluded from arbitration that cycle. The table update takes effect and the old values are not issued.
- flush_i: all entries invalid, pf_v_o=0 at the next edge. flush_i has priority over a same-cycle confirm, which is dropped.
- Address arithmetic wraps modulo 2^effective_addr_width_p; there is no page-boundary check.
- Negative strides are sign-extended before the add.
- stream_v_o reflects the registered entry valid bits.

Test Plan:
- Confirm pc=0x100, eff=0x1000, stride=0x40, degree=2, distance=1, ready=1 -> pf_v_o high 2 cycles later with addr 0x1040, next cycle 0x1080, then idle; stream_v_o=0001.
- Same stimulus with pf_ready_i=0 for 5 cycles -> pf_addr_o holds 0x1040 stable with pf_v_o=1; after ready rises, 0x1080 follows.
- stride=0x08 from eff=0x1000, degree=2 -> 0x1008 issued once; 0x1010 is in the same 64B line and is suppressed. Only one request appears.
- Five confirms with distinct PCs, streams_p=4 -> the 5th replaces entry 0 (victim pointer 0); a later start_discovery on the 5th PC invalidates entry 0; stream_v_o=1110.
- Negative stride 0xF8 (-8) from eff=0x0 with distance=1 -> pf_addr_o=0xFF..F8 (wrap); confirm with stride=0 -> no entry allocated.
- flush_i while pf_v_o=1 and ready=0, with a same-cycle confirm -> pf_v_o=0 next cycle, stream_v_o=0, confirm dropped. Then pull reset_n_i low mid-stream -> all outputs 0.

Source files
------------

// File: rtl/bp_be_stride_prefetch_gen.sv
// Stride prefetch generator: tracks confirmed load streams and issues
// prefetch addresses to the dcache prefetch port over ready/valid.
module bp_be_stride_prefetch_gen #(
  parameter int vaddr_width_p          = 39
 ,parameter int stride_width_p         = 8
 ,parameter int effective_addr_width_p = vaddr_width_p
 ,parameter int streams_p              = 4
 ,parameter int prefetch_degree_p      = 2
 ,parameter int prefetch_distance_p    = 1
 ,parameter int line_offset_width_p    = 6
) (
  input  logic                              clk_i
 ,input  logic                              reset_n_i
 ,input  logic                              start_discovery_i
 ,input  logic                              confirm_discovery_i
 ,input  logic [vaddr_width_p-1:0]          striding_pc_i
 ,input  logic [effective_addr_width_p-1:0] eff_addr_i
 ,input  logic [stride_width_p-1:0]         stride_i
 ,input  logic                              flush_i
 ,output logic                              pf_v_o
 ,output logic [effective_addr_width_p-1:0] pf_addr_o
 ,input  logic                              pf_ready_i
 ,output logic [streams_p-1:0]              stream_v_o
);

  localparam int iw_lp = $clog2(streams_p);
  localparam int ea_lp = effective_addr_width_p;
  localparam int lw_lp = ea_lp - line_offset_width_p;
  localparam logic [ea_lp-1:0] dist_lp = ea_lp'(prefetch_distance_p);
  localparam logic [2:0] degree_lp = 3'(prefetch_degree_p);

  logic [streams_p-1:0]     v_q, llv_q;
  logic [vaddr_width_p-1:0] pc_q     [streams_p];
  logic [ea_lp-1:0]         next_q   [streams_p];
  logic [ea_lp-1:0]         stride_q [streams_p];
  logic [2:0]               rem_q    [streams_p];
  logic [lw_lp-1:0]         ll_q     [streams_p];
  logic [iw_lp-1:0]         victim_q, last_q;
  logic                     pf_v_q;
  logic [ea_lp-1:0]         pf_addr_q;

  logic                 hit, free;
  logic [iw_lp-1:0]     hit_idx, free_idx, wr_idx;
  logic                 cfm, inv;
  logic [ea_lp-1:0]     stride_ext, new_next;
  logic [streams_p-1:0] wr_mask, req;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = streams_p-1; i >= 0; i--) begin
      if (v_q[i] && pc_q[i] == striding_pc_i) begin
        hit     = 1'b1;
        hit_idx = iw_lp'(i);
      end
      if (!v_q[i]) begin
        free     = 1'b1;
        free_idx = iw_lp'(i);
      end
    end
  end

  assign cfm = confirm_discovery_i && (stride_i != '0) && !flush_i;
  assign inv = start_discovery_i && !confirm_discovery_i
            && hit && !flush_i;
  assign wr_idx = hit ? hit_idx : (free ? free_idx : victim_q);
  assign stride_ext = {{(ea_lp-stride_width_p){stride_i[stride_width_p-1]}}
                      , stride_i};
  assign new_next = eff_addr_i + stride_ext * dist_lp;

  // Entries touched by the table update sit out arbitration this cycle
  always_comb begin
    wr_mask = '0;
    if (cfm)      wr_mask[wr_idx]  = 1'b1;
    else if (inv) wr_mask[hit_idx] = 1'b1;
    for (int i = 0; i < streams_p; i++)
      req[i] = v_q[i] && (rem_q[i] != '0) && !wr_mask[i];
  end

  logic             gnt_v;
  logic [iw_lp-1:0] gnt_idx, cand;

  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = last_q;
    cand    = last_q;
    for (int k = streams_p; k >= 1; k--) begin
      cand = last_q + iw_lp'(k);
      if (req[cand]) begin
        gnt_v   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  logic [ea_lp-1:0] sel_next;
  logic [lw_lp-1:0] sel_line;
  logic             dup, load_ok, issue;

  assign sel_next = next_q[gnt_idx];
  assign sel_line = sel_next[ea_lp-1:line_offset_width_p];
  assign dup      = llv_q[gnt_idx] && (ll_q[gnt_idx] == sel_line);
  assign load_ok  = !pf_v_q || pf_ready_i;
  assign issue    = load_ok && gnt_v;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q       <= '0;
      llv_q     <= '0;
      victim_q  <= '0;
      last_q    <= '0;
      pf_v_q    <= 1'b0;
      pf_addr_q <= '0;
    end else if (flush_i) begin
      v_q    <= '0;
      pf_v_q <= 1'b0;
    end else begin
      if (issue) begin
        next_q[gnt_idx] <= sel_next + stride_q[gnt_idx];
        rem_q[gnt_idx]  <= rem_q[gnt_idx] - 3'd1;
        last_q          <= gnt_idx;
        if (!dup) begin
          ll_q[gnt_idx]  <= sel_line;
          llv_q[gnt_idx] <= 1'b1;
          pf_addr_q      <= sel_next;
        end
      end
      if (load_ok) pf_v_q <= issue && !dup;
      if (cfm) begin
        v_q[wr_idx]      <= 1'b1;
        next_q[wr_idx]   <= new_next;
        stride_q[wr_idx] <= stride_ext;
        rem_q[wr_idx]    <= degree_lp;
        if (!hit) begin
          pc_q[wr_idx]  <= striding_pc_i;
          llv_q[wr_idx] <= 1'b0;
          if (!free) victim_q <= victim_q + 1'b1;
        end
      end else if (inv) begin
        v_q[hit_idx] <= 1'b0;
      end
    end
  end

  assign pf_v_o     = pf_v_q;
  assign pf_addr_o  = pf_addr_q;
  assign stream_v_o = v_q;

endmodule
